// File: rtl/axis_multi_splitter.sv
// Splits each AXI stream packet into NUM_OUTPUTS consecutive segments whose word
// lengths are sampled per packet; one registered output word, steered to one port.
module axis_multi_splitter #(
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1,
  parameter int NUM_OUTPUTS    = 3,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                                   clk,
  input  logic                                   sresetn,
  input  logic [(NUM_OUTPUTS-1)*LEN_WIDTH-1:0]   split_len,
  input  logic                                   axis_i_tvalid,
  output logic                                   axis_i_tready,
  input  logic                                   axis_i_tlast,
  input  logic [AXIS_BYTES*8-1:0]                axis_i_tdata,
  input  logic [AXIS_USER_BITS-1:0]              axis_i_tuser,
  output logic [NUM_OUTPUTS-1:0]                 axis_o_tvalid,
  input  logic [NUM_OUTPUTS-1:0]                 axis_o_tready,
  output logic [NUM_OUTPUTS-1:0]                 axis_o_tlast,
  output logic [NUM_OUTPUTS*AXIS_BYTES*8-1:0]    axis_o_tdata,
  output logic [NUM_OUTPUTS*AXIS_USER_BITS-1:0]  axis_o_tuser,
  output logic                                   short_pkt
);

  localparam int DW    = AXIS_BYTES * 8;
  localparam int SEG_W = $clog2(NUM_OUTPUTS);
  localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(NUM_OUTPUTS - 1);

  typedef logic [NUM_OUTPUTS-2:0][LEN_WIDTH-1:0] len_vec_t;
  typedef logic [NUM_OUTPUTS-1:0][LEN_WIDTH-1:0] len_all_t;

  logic                      first;
  logic [SEG_W-1:0]          seg;
  logic [LEN_WIDTH-1:0]      ctr;
  len_vec_t                  len_q;

  len_vec_t                  len_cur;
  len_all_t                  len_all;
  logic [SEG_W-1:0]          cur_seg;
  logic [SEG_W-1:0]          nxt_seg;
  logic [LEN_WIDTH-1:0]      cur_ctr;
  logic [LEN_WIDTH-1:0]      ctr_inc;
  logic                      seg_end;
  logic                      in_ready;
  logic                      accept;

  logic                      out_valid;
  logic                      out_last;
  logic [SEG_W-1:0]          out_dest;
  logic [DW-1:0]             out_data;
  logic [AXIS_USER_BITS-1:0] out_user;
  logic                      short_q;

  // Lowest segment index >= from whose length is non-zero; the final segment
  // is the fallback since it has no length of its own.
  function automatic logic [SEG_W-1:0] first_nonzero_from(input len_all_t lens,
                                                          input logic [SEG_W:0] from);
    logic [SEG_W-1:0] r;
    r = LAST_SEG;
    for (int unsigned k = NUM_OUTPUTS - 1; k > 0; k--) begin
      if (32'(from) <= (k - 1) && lens[SEG_W'(k - 1)] != '0)
        r = SEG_W'(k - 1);
    end
    return r;
  endfunction

  always_comb begin
    len_cur = first ? len_vec_t'(split_len) : len_q;
    len_all = {LEN_WIDTH'(0), len_cur};
    // seg/ctr registers hold start-of-packet values only after tlast; the
    // starting segment depends on the lengths seen on the first beat.
    cur_seg = first ? first_nonzero_from(len_all, '0) : seg;
    cur_ctr = first ? '0 : ctr;
    ctr_inc = cur_ctr + 1'b1;
    seg_end = (cur_seg != LAST_SEG) && (ctr_inc == len_all[cur_seg]);
    nxt_seg = first_nonzero_from(len_all, {1'b0, cur_seg} + 1'b1);
  end

  assign in_ready      = !out_valid || axis_o_tready[out_dest];
  assign accept        = axis_i_tvalid && in_ready;
  assign axis_i_tready = in_ready;

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_dest  <= '0;
      out_data  <= '0;
      out_user  <= '0;
      short_q   <= 1'b0;
      seg       <= '0;
      ctr       <= '0;
      first     <= 1'b1;
      len_q     <= '0;
    end else begin
      short_q <= 1'b0;
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= axis_i_tdata;
        out_user  <= axis_i_tuser;
        out_dest  <= cur_seg;
        out_last  <= axis_i_tlast || seg_end;
        short_q   <= axis_i_tlast && (cur_seg != LAST_SEG);
        if (first)
          len_q <= len_cur;
        if (axis_i_tlast) begin
          first <= 1'b1;
          seg   <= '0;
          ctr   <= '0;
        end else begin
          first <= 1'b0;
          if (seg_end) begin
            seg <= nxt_seg;
            ctr <= '0;
          end else begin
            seg <= cur_seg;
            ctr <= ctr_inc;
          end
        end
      end else if (out_valid && axis_o_tready[out_dest]) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    axis_o_tvalid = '0;
    axis_o_tlast  = '0;
    if (out_valid) begin
      axis_o_tvalid[out_dest] = 1'b1;
      axis_o_tlast[out_dest]  = out_last;
    end
  end

  assign axis_o_tdata = {NUM_OUTPUTS{out_data}};
  assign axis_o_tuser = {NUM_OUTPUTS{out_user}};
  assign short_pkt    = short_q;

endmodule

// File: tb/tb_axis_multi_splitter.sv
// Randomized self-checking bench for axis_multi_splitter with a segment-boundary
// reference model computed from cumulative lengths.
module tb_axis_multi_splitter;

  logic        clk = 1'b0;
  logic        sresetn = 1'b0;
  logic [31:0] split_len = '0;
  logic        axis_i_tvalid = 1'b0;
  logic        axis_i_tready;
  logic        axis_i_tlast = 1'b0;
  logic [7:0]  axis_i_tdata = '0;
  logic [0:0]  axis_i_tuser = '0;
  logic [2:0]  axis_o_tvalid;
  logic [2:0]  axis_o_tready;
  logic [2:0]  axis_o_tlast;
  logic [23:0] axis_o_tdata;
  logic [2:0]  axis_o_tuser;
  logic        short_pkt;

  axis_multi_splitter #(
    .AXIS_BYTES(1), .AXIS_USER_BITS(1), .NUM_OUTPUTS(3), .LEN_WIDTH(16)
  ) dut (
    .clk(clk), .sresetn(sresetn), .split_len(split_len),
    .axis_i_tvalid(axis_i_tvalid), .axis_i_tready(axis_i_tready),
    .axis_i_tlast(axis_i_tlast), .axis_i_tdata(axis_i_tdata), .axis_i_tuser(axis_i_tuser),
    .axis_o_tvalid(axis_o_tvalid), .axis_o_tready(axis_o_tready),
    .axis_o_tlast(axis_o_tlast), .axis_o_tdata(axis_o_tdata), .axis_o_tuser(axis_o_tuser),
    .short_pkt(short_pkt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ready_mode = 0;            // 0: all ready, 1: random, 2: bp_ready
  logic [2:0] rnd_ready = '1;
  logic [2:0] bp_ready = '1;

  always @(posedge clk) begin
    #1 rnd_ready = 3'($urandom);
  end
  always_comb axis_o_tready = (ready_mode == 1) ? rnd_ready : (ready_mode == 2) ? bp_ready : 3'b111;

  // {tlast, tuser, tdata} per transfer, cumulative over the run
  logic [9:0] cap_q[3][$];
  logic [9:0] exp_q[3][$];
  int ptr[3];
  int short_cnt = 0, short_bad = 0, multi_cnt = 0, exp_short = 0;
  logic [7:0] pkt_d[64];
  logic       pkt_u[64];

  always @(negedge clk) begin
    if (sresetn) begin
      for (int k = 0; k < 3; k++)
        if (axis_o_tvalid[k] && axis_o_tready[k])
          cap_q[k].push_back({axis_o_tlast[k], axis_o_tuser[k], axis_o_tdata[k*8 +: 8]});
      if ($countones(axis_o_tvalid) > 1) multi_cnt++;
      if (short_pkt) begin
        short_cnt++;
        if ((axis_o_tvalid & axis_o_tlast) == 3'b000) short_bad++;
      end
    end
  end

  task automatic fill_pkt(input int plen);
    for (int i = 0; i < plen; i++) begin
      pkt_d[i] = 8'($urandom);
      pkt_u[i] = 1'($urandom);
    end
  endtask

  // Segment 0 covers words [0,l0), segment 1 covers [l0,l0+l1), segment 2 the rest.
  task automatic model_pkt(input int plen, input int l0, input int l1);
    for (int i = 0; i < plen; i++) begin
      int s;
      logic last;
      s = (i < l0) ? 0 : (i < l0 + l1) ? 1 : 2;
      last = (i == plen - 1) || (s == 0 && i == l0 - 1) || (s == 1 && i == l0 + l1 - 1);
      exp_q[s].push_back({last, pkt_u[i], pkt_d[i]});
      if (i == plen - 1 && s != 2) exp_short++;
    end
  endtask

  // Called and returns at #1 after a rising edge.
  task automatic send_pkt(input int plen, input int nsend, input bit gaps,
                          input bit change, input logic [31:0] new_len);
    for (int i = 0; i < nsend; i++) begin
      bit rdy;
      int n;
      if (gaps && $urandom_range(0, 3) == 0) begin
        axis_i_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      axis_i_tvalid = 1'b1;
      axis_i_tdata  = pkt_d[i];
      axis_i_tuser  = pkt_u[i];
      axis_i_tlast  = (i == plen - 1);
      rdy = 1'b0;
      n = 0;
      while (!rdy && n < 500) begin
        @(negedge clk); rdy = axis_i_tready;
        @(posedge clk); #1;
        n++;
      end
      if (!rdy) begin
        checks++; failures++;
        $display("FAIL input_accept_timeout beat=%0d got=tready_low required=accept", i);
      end
      if (change && i == 0) split_len = new_len;
    end
    axis_i_tvalid = 1'b0;
    axis_i_tlast  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    bit idle = 1'b0;
    while (!idle && n < 400) begin
      @(negedge clk);
      idle = (axis_o_tvalid == 3'b000);
      n++;
    end
    @(posedge clk); #1;
    if (!idle) begin
      checks++; failures++;
      $display("FAIL drain_timeout got=tvalid_%b required=000", axis_o_tvalid);
    end
  endtask

  task automatic test_reset();
    sresetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (axis_o_tvalid !== 3'b000) begin failures++; $display("FAIL reset_tvalid got=%b required=000", axis_o_tvalid); end
    checks++; if (short_pkt !== 1'b0) begin failures++; $display("FAIL reset_short got=%b required=0", short_pkt); end
    checks++; if (axis_i_tready !== 1'b1) begin failures++; $display("FAIL reset_tready got=%b required=1", axis_i_tready); end
    sresetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    ready_mode = 0;
    split_len = {16'd3, 16'd2}; fill_pkt(8); model_pkt(8, 2, 3); send_pkt(8, 8, 0, 0, '0);
    split_len = {16'd2, 16'd0}; fill_pkt(4); model_pkt(4, 0, 2); send_pkt(4, 4, 0, 0, '0);
    split_len = {16'd3, 16'd2}; fill_pkt(3); model_pkt(3, 2, 3); send_pkt(3, 3, 0, 0, '0);
    fill_pkt(4); model_pkt(4, 2, 3); send_pkt(4, 4, 0, 0, '0);
    wait_idle();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cap_q[k].size() != exp_q[k].size()) begin failures++; $display("FAIL basic_count out%0d got=%0d required=%0d", k, cap_q[k].size(), exp_q[k].size()); end
      for (int i = ptr[k]; i < exp_q[k].size() && i < cap_q[k].size(); i++) begin
        checks++;
        if (cap_q[k][i] !== exp_q[k][i]) begin failures++; $display("FAIL basic_word out%0d[%0d] got=%h required=%h", k, i, cap_q[k][i], exp_q[k][i]); end
      end
      ptr[k] = exp_q[k].size();
    end
    checks++; if (short_cnt != exp_short) begin failures++; $display("FAIL basic_short_count got=%0d required=%0d", short_cnt, exp_short); end
    checks++; if (short_bad != 0) begin failures++; $display("FAIL basic_short_align got=%0d required=0", short_bad); end
  endtask

  task automatic test_backpressure();
    ready_mode = 2;
    bp_ready = 3'b111;
    split_len = {16'd3, 16'd2}; fill_pkt(8); model_pkt(8, 2, 3);
    fork
      send_pkt(8, 8, 0, 0, '0);
      begin
        int n = 0;
        logic [7:0] held_d;
        logic       held_l;
        while (!axis_o_tvalid[1] && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (!axis_o_tvalid[1]) begin failures++; $display("FAIL bp_wait got=no_out1_valid required=out1_valid"); end
        bp_ready = 3'b101;
        held_d = axis_o_tdata[15:8];
        held_l = axis_o_tlast[1];
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          checks++;
          if (axis_o_tvalid !== 3'b010 || axis_o_tdata[15:8] !== held_d || axis_o_tlast[1] !== held_l || axis_i_tready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold cycle=%0d got=v%b d%h l%b rdy%b required=v010 d%h l%b rdy0",
                     c, axis_o_tvalid, axis_o_tdata[15:8], axis_o_tlast[1], axis_i_tready, held_d, held_l);
          end
        end
        @(posedge clk); #1;
        bp_ready = 3'b111;
      end
    join
    wait_idle();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cap_q[k].size() != exp_q[k].size()) begin failures++; $display("FAIL bp_count out%0d got=%0d required=%0d", k, cap_q[k].size(), exp_q[k].size()); end
      for (int i = ptr[k]; i < exp_q[k].size() && i < cap_q[k].size(); i++) begin
        checks++;
        if (cap_q[k][i] !== exp_q[k][i]) begin failures++; $display("FAIL bp_word out%0d[%0d] got=%h required=%h", k, i, cap_q[k][i], exp_q[k][i]); end
      end
      ptr[k] = exp_q[k].size();
    end
    ready_mode = 0;
  endtask

  task automatic test_len_change();
    ready_mode = 0;
    split_len = {16'd3, 16'd2}; fill_pkt(8); model_pkt(8, 2, 3);
    send_pkt(8, 8, 0, 1, {16'd1, 16'd1});
    fill_pkt(4); model_pkt(4, 1, 1); send_pkt(4, 4, 0, 0, '0);
    wait_idle();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cap_q[k].size() != exp_q[k].size()) begin failures++; $display("FAIL lenchg_count out%0d got=%0d required=%0d", k, cap_q[k].size(), exp_q[k].size()); end
      for (int i = ptr[k]; i < exp_q[k].size() && i < cap_q[k].size(); i++) begin
        checks++;
        if (cap_q[k][i] !== exp_q[k][i]) begin failures++; $display("FAIL lenchg_word out%0d[%0d] got=%h required=%h", k, i, cap_q[k][i], exp_q[k][i]); end
      end
      ptr[k] = exp_q[k].size();
    end
  endtask

  task automatic test_mid_reset();
    ready_mode = 0;
    split_len = {16'd3, 16'd2}; fill_pkt(8);
    exp_q[0].push_back({1'b0, pkt_u[0], pkt_d[0]});
    exp_q[0].push_back({1'b1, pkt_u[1], pkt_d[1]});
    send_pkt(8, 3, 0, 0, '0);      // third word is still in the output register
    sresetn = 1'b0;
    @(posedge clk); #1;
    sresetn = 1'b1;
    checks++; if (axis_o_tvalid !== 3'b000) begin failures++; $display("FAIL midrst_tvalid got=%b required=000", axis_o_tvalid); end
    split_len = {16'd1, 16'd1}; fill_pkt(4); model_pkt(4, 1, 1); send_pkt(4, 4, 0, 0, '0);
    wait_idle();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cap_q[k].size() != exp_q[k].size()) begin failures++; $display("FAIL midrst_count out%0d got=%0d required=%0d", k, cap_q[k].size(), exp_q[k].size()); end
      for (int i = ptr[k]; i < exp_q[k].size() && i < cap_q[k].size(); i++) begin
        checks++;
        if (cap_q[k][i] !== exp_q[k][i]) begin failures++; $display("FAIL midrst_word out%0d[%0d] got=%h required=%h", k, i, cap_q[k][i], exp_q[k][i]); end
      end
      ptr[k] = exp_q[k].size();
    end
  endtask

  task automatic test_random();
    ready_mode = 1;
    for (int p = 0; p < 40; p++) begin
      int plen, l0, l1;
      plen = $urandom_range(1, 12);
      l0 = $urandom_range(0, 4);
      l1 = $urandom_range(0, 4);
      split_len = {16'(l1), 16'(l0)};
      fill_pkt(plen);
      model_pkt(plen, l0, l1);
      send_pkt(plen, plen, 1, ($urandom_range(0, 2) == 0), {16'($urandom_range(0, 4)), 16'($urandom_range(0, 4))});
    end
    wait_idle();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cap_q[k].size() != exp_q[k].size()) begin failures++; $display("FAIL rand_count out%0d got=%0d required=%0d", k, cap_q[k].size(), exp_q[k].size()); end
      for (int i = ptr[k]; i < exp_q[k].size() && i < cap_q[k].size(); i++) begin
        checks++;
        if (cap_q[k][i] !== exp_q[k][i]) begin failures++; $display("FAIL rand_word out%0d[%0d] got=%h required=%h", k, i, cap_q[k][i], exp_q[k][i]); end
      end
      ptr[k] = exp_q[k].size();
    end
    checks++; if (short_cnt != exp_short) begin failures++; $display("FAIL rand_short_count got=%0d required=%0d", short_cnt, exp_short); end
    checks++; if (short_bad != 0) begin failures++; $display("FAIL rand_short_align got=%0d required=0", short_bad); end
    checks++; if (multi_cnt != 0) begin failures++; $display("FAIL onehot_valid got=%0d required=0", multi_cnt); end
    ready_mode = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 3; k++) ptr[k] = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_len_change();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
